// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM access sequencer: FSM encoding, latencies, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_seq_pkg;

    // Default geometry: 2K x 8 RAM, bursts of up to 255 words.
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    // RAM q follows the command by RD_LAT cycles; vid_valid follows the
    // command by OUT_LAT cycles, because mem_q is registered once more
    // before reaching the outputs.
    localparam int RD_LAT  = 1;
    localparam int OUT_LAT = RD_LAT + 1;

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_CPU_CMD  = 3'd2,
        ST_CPU_WAIT = 3'd3,
        ST_BURST    = 3'd4
    } seq_state_t;

    // Travels alongside each read command until the RAM returns its data.
    typedef struct packed {
        logic vld;   // a read was issued in this slot
        logic vid;   // 1 = video burst word, 0 = CPU read
        logic last;  // final word of a video burst
    } rd_tag_t;

endpackage

// File: rtl/ram_seq_rdpipe.sv
// Read-return pipeline: delays per-read tags by the RAM latency, steers mem_q to CPU or video.
// Latency: tag enters alongside the registered RAM command; result registered OUT_LAT cycles after it.
// Backpressure: none; every returned word is presented exactly once.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   iss_rd_vld/vid/last       tag of the read currently on the RAM port
//   mem_q                     RAM registered read data
//   rd_ack, cpu_rdata         CPU read completion pulse and held read data
//   vid_valid/data/last       video burst word stream
module ram_seq_rdpipe
    import ram_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iss_rd_vld,
    input  logic              iss_vid,
    input  logic              iss_last,
    input  logic [DATA_W-1:0] mem_q,
    output logic              rd_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_last
);

    rd_tag_t           pipe_q [RD_LAT];
    rd_tag_t           pipe_d [RD_LAT];
    rd_tag_t           head;

    logic              rd_ack_q,    rd_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_data_q,  vid_data_d;
    logic              vid_last_q,  vid_last_d;

    always_comb begin
        pipe_d[0] = '{vld: iss_rd_vld, vid: iss_vid, last: iss_last};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // The oldest slot lines up with the cycle its data sits on mem_q.
        head = pipe_q[RD_LAT-1];

        vid_valid_d = head.vld & head.vid;
        vid_last_d  = head.vld & head.vid & head.last;
        vid_data_d  = (head.vld & head.vid) ? mem_q : vid_data_q;

        rd_ack_d    = head.vld & ~head.vid;
        cpu_rdata_d = (head.vld & ~head.vid) ? mem_q : cpu_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            rd_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            vid_last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            rd_ack_q    <= rd_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            vid_last_q  <= vid_last_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;
    assign vid_last  = vid_last_q;

endmodule

// File: rtl/ram_access_sequencer.sv
// Sole initiator of a single-port sync RAM: arbitrates CPU single-word accesses against video burst reads.
// Latency: CPU write ack 2 cycles, CPU read ack 3 cycles, burst word k valid 3+k cycles after acceptance.
// Backpressure: CPU waits on req/ack; video bursts have none (one word per cycle, consumer must keep up).
//
// Ports:
//   clock, reset                       single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack/rdata   CPU single-word request/acknowledge
//   vid_start/base/len -> vid_busy/valid/data/last   video burst request and word stream
//   mem_clken/wren/address/data, mem_q        RAM port (all outgoing signals registered)
//   clear_busy                          post-reset RAM clear in progress
// Build option: define RAM_CLEAR_EN to zero the whole RAM after every reset.
module ram_access_sequencer
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_start,
    input  logic [ADDR_W-1:0] vid_base,
    input  logic [LEN_W-1:0]  vid_len,
    output logic              vid_busy,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_last,
    output logic              mem_clken,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              clear_busy
);

`ifdef RAM_CLEAR_EN
    localparam seq_state_t RESET_STATE = ST_CLEAR;
`else
    localparam seq_state_t RESET_STATE = ST_IDLE;
`endif

    seq_state_t        state_q,       state_d;
    logic              mem_clken_q,   mem_clken_d;
    logic              mem_wren_q,    mem_wren_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q,    mem_data_d;
    logic              iss_vid_q,     iss_vid_d;
    logic              iss_last_q,    iss_last_d;
    logic [ADDR_W-1:0] bst_addr_q,    bst_addr_d;
    logic [LEN_W-1:0]  bst_cnt_q,     bst_cnt_d;
    logic              vid_busy_q,    vid_busy_d;
    logic              wr_ack_q,      wr_ack_d;
    logic              rd_ack;
`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q,    clr_addr_d;
    logic              clear_busy_q,  clear_busy_d;
`endif

    logic vid_accept;
    logic cpu_accept;

    // A burst is taken only when no earlier burst is still draining; a
    // zero-length start is simply dropped.
    assign vid_accept = vid_start && (vid_len != '0) && !vid_busy_q;
    // cpu_req is still high during the ack cycle; do not re-issue it.
    assign cpu_accept = cpu_req && !cpu_ack;

    always_comb begin
        state_d       = state_q;
        mem_clken_d   = 1'b0;
        mem_wren_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        iss_vid_d     = 1'b0;
        iss_last_d    = 1'b0;
        bst_addr_d    = bst_addr_q;
        bst_cnt_d     = bst_cnt_q;
        wr_ack_d      = 1'b0;
        // Busy drops right after the final word is delivered.
        vid_busy_d    = vid_busy_q & ~vid_last;
`ifdef RAM_CLEAR_EN
        clr_addr_d    = clr_addr_q;
        clear_busy_d  = 1'b0;
`endif

        case (state_q)
`ifdef RAM_CLEAR_EN
            ST_CLEAR: begin
                mem_clken_d   = 1'b1;
                mem_wren_d    = 1'b1;
                mem_address_d = clr_addr_q;
                mem_data_d    = '0;
                clear_busy_d  = 1'b1;
                clr_addr_d    = clr_addr_q + ADDR_W'(1);
                if (&clr_addr_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (vid_accept) begin
                    // Word 0 is issued straight from IDLE; the rest come from
                    // the latched address/count in BURST.
                    mem_clken_d   = 1'b1;
                    mem_address_d = vid_base;
                    iss_vid_d     = 1'b1;
                    iss_last_d    = (vid_len == LEN_W'(1));
                    bst_addr_d    = vid_base + ADDR_W'(1);
                    bst_cnt_d     = vid_len - LEN_W'(1);
                    vid_busy_d    = 1'b1;
                    state_d       = (vid_len == LEN_W'(1)) ? ST_IDLE : ST_BURST;
                end else if (cpu_accept) begin
                    mem_clken_d   = 1'b1;
                    mem_wren_d    = cpu_we;
                    mem_address_d = cpu_addr;
                    mem_data_d    = cpu_wdata;
                    state_d       = ST_CPU_CMD;
                end
            end
            ST_CPU_CMD: begin
                // Writes complete as soon as the command is on the port;
                // reads are acknowledged by the read pipeline.
                if (mem_wren_q) begin
                    wr_ack_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_CPU_WAIT;
                end
            end
            ST_CPU_WAIT: begin
                state_d = ST_IDLE;
            end
            ST_BURST: begin
                // bst_cnt_q counts words still to issue. Leaving on the last
                // issue lets a waiting CPU op go out with no idle gap.
                mem_clken_d   = 1'b1;
                mem_address_d = bst_addr_q;
                iss_vid_d     = 1'b1;
                iss_last_d    = (bst_cnt_q == LEN_W'(1));
                bst_addr_d    = bst_addr_q + ADDR_W'(1);
                bst_cnt_d     = bst_cnt_q - LEN_W'(1);
                if (bst_cnt_q == LEN_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            mem_clken_q   <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            iss_vid_q     <= 1'b0;
            iss_last_q    <= 1'b0;
            bst_addr_q    <= '0;
            bst_cnt_q     <= '0;
            vid_busy_q    <= 1'b0;
            wr_ack_q      <= 1'b0;
`ifdef RAM_CLEAR_EN
            clr_addr_q    <= '0;
            clear_busy_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_clken_q   <= mem_clken_d;
            mem_wren_q    <= mem_wren_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            iss_vid_q     <= iss_vid_d;
            iss_last_q    <= iss_last_d;
            bst_addr_q    <= bst_addr_d;
            bst_cnt_q     <= bst_cnt_d;
            vid_busy_q    <= vid_busy_d;
            wr_ack_q      <= wr_ack_d;
`ifdef RAM_CLEAR_EN
            clr_addr_q    <= clr_addr_d;
            clear_busy_q  <= clear_busy_d;
`endif
        end
    end

    ram_seq_rdpipe #(
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clock      (clock),
        .reset      (reset),
        .iss_rd_vld (mem_clken_q & ~mem_wren_q),
        .iss_vid    (iss_vid_q),
        .iss_last   (iss_last_q),
        .mem_q      (mem_q),
        .rd_ack     (rd_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_valid  (vid_valid),
        .vid_data   (vid_data),
        .vid_last   (vid_last)
    );

    assign cpu_ack     = wr_ack_q | rd_ack;
    assign vid_busy    = vid_busy_q;
    assign mem_clken   = mem_clken_q;
    assign mem_wren    = mem_wren_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
`ifdef RAM_CLEAR_EN
    assign clear_busy  = clear_busy_q;
`else
    assign clear_busy  = 1'b0;
`endif

endmodule
